// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: round-robin sharing of the SPI config flash between two SPI masters,
// switching owners only while the owner's CS is high and inserting a CS-high gap.
module spi_flash_arbiter #(
    parameter int GAP_CYCLES    = 4,
    parameter int MAX_HOLD_IDLE = 1024
) (
    input  logic       clk_48mhz,
    input  logic       resetn,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       owner,
    input  logic [1:0] m_sck,
    input  logic [1:0] m_csn,
    input  logic [1:0] m_mosi,
    output logic [1:0] m_miso,
    output logic       flash_sck,
    output logic       flash_csn,
    output logic       flash_mosi,
    input  logic       flash_miso
);
    localparam int HW = MAX_HOLD_IDLE > 0 ? $clog2(MAX_HOLD_IDLE + 1) : 1;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD_IDLE);
    localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t        state, state_n;
    logic          last, last_n, owner_n;
    logic [1:0]    gnt_n;
    logic          sck_n, csn_n, mosi_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic          win, rel, idle_wait;

    // on a tie the port that did not own last wins
    assign win       = (req == 2'b11) ? ~last : req[1];
    assign idle_wait = m_csn[owner] & req[~owner];
    // preemption only fires with the owner's CS high so a transfer is never cut
    assign rel       = m_csn[owner] & (~req[owner] | (MAX_HOLD_IDLE != 0 && hold_cnt == HOLD_MAX));
    assign m_miso    = {busy & owner & flash_miso, busy & ~owner & flash_miso};

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        gnt_n   = 2'b00;
        sck_n   = 1'b0;
        csn_n   = 1'b1;
        mosi_n  = 1'b0;
        hold_n  = '0;
        gap_n   = gap_cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = OWN;
                    owner_n = win;
                    last_n  = win;
                    gnt_n   = win ? 2'b10 : 2'b01;
                end
            end
            OWN: begin
                if (rel) begin
                    state_n = GAP_CYCLES == 0 ? IDLE : GAP;
                    gap_n   = GAP_INIT;
                end else begin
                    gnt_n  = gnt;
                    sck_n  = m_sck[owner];
                    csn_n  = m_csn[owner];
                    mosi_n = m_mosi[owner];
                    hold_n = idle_wait ? (hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + 1'b1) : '0;
                end
            end
            GAP: begin
                gap_n   = gap_cnt == '0 ? '0 : gap_cnt - 1'b1;
                state_n = gap_cnt == '0 ? IDLE : GAP;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (!resetn) begin
            state      <= IDLE;
            gnt        <= 2'b00;
            busy       <= 1'b0;
            owner      <= 1'b0;
            last       <= 1'b1;
            flash_sck  <= 1'b0;
            flash_csn  <= 1'b1;
            flash_mosi <= 1'b0;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            busy       <= state_n == OWN;
            owner      <= owner_n;
            last       <= last_n;
            flash_sck  <= sck_n;
            flash_csn  <= csn_n;
            flash_mosi <= mosi_n;
            hold_cnt   <= hold_n;
            gap_cnt    <= gap_n;
        end
    end
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb_spi_flash_arbiter: directed checks of grant, forwarding, gap and preemption behaviour.
module tb_spi_flash_arbiter;
    logic       clk_48mhz = 1'b0;
    logic       resetn;
    logic [1:0] req, m_sck, m_csn, m_mosi;
    logic       flash_miso;
    logic [1:0] gnt, m_miso, gnt2, m_miso2;
    logic       busy, owner, flash_sck, flash_csn, flash_mosi;
    logic       busy2, owner2, flash_sck2, flash_csn2, flash_mosi2;
    int         checks = 0;
    int         failures = 0;

    always #5 clk_48mhz = ~clk_48mhz;

    spi_flash_arbiter #(.GAP_CYCLES(4), .MAX_HOLD_IDLE(16)) dut (
        .clk_48mhz(clk_48mhz), .resetn(resetn), .req(req), .gnt(gnt), .busy(busy),
        .owner(owner), .m_sck(m_sck), .m_csn(m_csn), .m_mosi(m_mosi), .m_miso(m_miso),
        .flash_sck(flash_sck), .flash_csn(flash_csn), .flash_mosi(flash_mosi),
        .flash_miso(flash_miso)
    );

    spi_flash_arbiter #(.GAP_CYCLES(4), .MAX_HOLD_IDLE(0)) dut_nopre (
        .clk_48mhz(clk_48mhz), .resetn(resetn), .req(req), .gnt(gnt2), .busy(busy2),
        .owner(owner2), .m_sck(m_sck), .m_csn(m_csn), .m_mosi(m_mosi), .m_miso(m_miso2),
        .flash_sck(flash_sck2), .flash_csn(flash_csn2), .flash_mosi(flash_mosi2),
        .flash_miso(flash_miso)
    );

    task automatic step();
        @(posedge clk_48mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // counts idle cycles after a release until the next grant; csn must stay high
    task automatic wait_gnt(input string tag, input logic [1:0] exp, input int exp_n);
        int   n = 0;
        logic csn_low = 1'b0;
        step();
        while (gnt == 2'b00 && n < 30) begin
            if (flash_csn !== 1'b1) csn_low = 1'b1;
            n++;
            step();
        end
        chk({tag, "_gnt"}, gnt, exp);
        chk({tag, "_gap"}, n, exp_n);
        chk({tag, "_csn"}, csn_low, 0);
    endtask

    initial begin
        logic [7:0] pat = 8'hA5;
        int         k;
        resetn = 0; req = 2'b11; m_sck = 2'b00; m_csn = 2'b11; m_mosi = 2'b00; flash_miso = 1'b1;
        step(); step();
        // T1 reset
        chk("t1_gnt", gnt, 2'b00);
        chk("t1_csn", flash_csn, 1);
        chk("t1_sck", flash_sck, 0);
        chk("t1_busy", busy, 0);
        chk("t1_miso", m_miso, 2'b00);
        chk("t1_gnt2", gnt2, 2'b00);
        // T2 single request and forwarding
        resetn = 1; req = 2'b01;
        step();
        chk("t2_gnt", gnt, 2'b01);
        chk("t2_busy", busy, 1);
        chk("t2_owner", owner, 0);
        chk("t2_csn_hi", flash_csn, 1);
        m_csn = 2'b00;
        step();
        chk("t2_csn_lo", flash_csn, 0);
        chk("t2_miso", m_miso, 2'b01);
        m_sck[1] = 1'b1; m_mosi[1] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m_sck[0]  = i[0];
            m_mosi[0] = pat[7 - i / 2];
            step();
            chk("t2_burst", {flash_sck, flash_mosi, flash_csn, m_miso[1]}, {m_sck[0], pat[7 - i / 2], 2'b00});
        end
        m_csn = 2'b11; m_sck = 2'b00; m_mosi = 2'b00;
        step();
        chk("t2_end", {gnt, flash_csn}, {2'b01, 1'b1});
        // T3 tie and round-robin
        resetn = 0; req = 2'b11;
        step();
        resetn = 1;
        step();
        chk("t3_tie", gnt, 2'b01);
        req = 2'b10;
        step();
        chk("t3_rel", {gnt, flash_csn, busy}, {2'b00, 1'b1, 1'b0});
        wait_gnt("t3_a", 2'b10, 4);
        req = 2'b01;
        step();
        req = 2'b11;
        wait_gnt("t3_b", 2'b01, 4);
        req = 2'b10;
        step();
        req = 2'b11;
        wait_gnt("t3_c", 2'b10, 4);
        req = 2'b01;
        step();
        req = 2'b11;
        wait_gnt("t3_d", 2'b01, 4);
        // T4 owner drops req mid-transfer
        req = 2'b01; m_csn = 2'b10;
        step();
        chk("t4_csn_lo", flash_csn, 0);
        req = 2'b00; m_sck = 2'b01;
        step();
        chk("t4_hold", {gnt, flash_sck, flash_csn}, {2'b01, 1'b1, 1'b0});
        m_sck = 2'b00;
        step();
        chk("t4_fwd", {gnt, flash_sck, flash_csn}, {2'b01, 1'b0, 1'b0});
        m_csn = 2'b11;
        step();
        chk("t4_rel", {gnt, flash_csn, busy}, {2'b00, 1'b1, 1'b0});
        req = 2'b10;
        wait_gnt("t4", 2'b10, 4);
        // T5 preemption after 16 idle cycles; no preemption with MAX_HOLD_IDLE=0
        resetn = 0; req = 2'b00;
        step();
        resetn = 1; req = 2'b01;
        step();
        chk("t5_gnt", {gnt, gnt2}, {2'b01, 2'b01});
        req = 2'b11;
        k = 0;
        do begin
            step();
            k++;
        end while (gnt == 2'b01 && k < 40);
        chk("t5_hold", k, 17);
        chk("t5_rel", gnt, 2'b00);
        wait_gnt("t5", 2'b10, 4);
        chk("t5_nopre", gnt2, 2'b01);
        // T6 reset mid-transfer
        m_csn = 2'b01;
        step();
        chk("t6_csn_lo", flash_csn, 0);
        resetn = 0;
        step();
        chk("t6_rst", {gnt, flash_csn, busy}, {2'b00, 1'b1, 1'b0});
        resetn = 1; req = 2'b00; m_csn = 2'b11;
        step();
        chk("t6_idle", gnt, 2'b00);
        req = 2'b11;
        step();
        chk("t6_tie", gnt, 2'b01);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
